inst_sequencer: RTL and testbench
=================================

Name: inst_sequencer

Overview:
- Upstream instruction-feed stage for tt_um_8bit_cpu. Holds a small program buffer of 16-bit instruction words, loaded through a valid/ready handshake.
- On command it replays the buffer one word per clock onto the core's instruction inputs: opcode/R1 byte and R2/R3/data byte.
- When the sequencer is not running it drives the NOP encoding, so the core's register file and data_out stay untouched.

Parameters:
- DEPTH, 16, number of instruction words in the program buffer (power of two, at least 2).
- ADDR_W, 4, log2(DEPTH).
- NOP_WORD, 16'h4000, word driven when not issuing (opcode 4'b0100 = NOP).

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous reset, active-high.
- load_valid  input  1  load_word is valid this cycle.
- load_word  input  16  instruction to append: [15:8] goes to the core's ui_in, [7:0] to its uio_in.
- load_ready  output  1  buffer accepts a word this cycle.
- clear  input  1  empty the buffer (prog_len := 0).
- start  input  1  begin replay from address 0.
- stop  input  1  abort replay and return to IDLE.
- hold  input  1  pause replay; PC frozen and NOP issued.
- loop_en  input  1  wrap to address 0 after the last word instead of finishing.
- inst_hi  output  8  to the core's ui_in (opcode, R1).
- inst_lo  output  8  to the core's uio_in (R2/R3 or immediate data).
- inst_valid  output  1  inst_hi/inst_lo carry a program word, not NOP.
- busy  output  1  state is RUN.
- done  output  1  one-cycle pulse when a non-looping replay finishes.
- prog_len  output  ADDR_W+1  number of words currently loaded (0..DEPTH).

Behaviour:
- Reset values:
  - state IDLE; wr_ptr=0, prog_len=0, pc=0.
  - {inst_hi,inst_lo}=NOP_WORD; inst_valid=0, busy=0, done=0.
  - load_ready=1.
  - Buffer contents are not reset.
- States:
  - IDLE: accepts loads. `start` with prog_len>0 moves to RUN. `start` with prog_len==0 is ignored.
  - RUN: issues one word per cycle.
  - DONE: lasts exactly one cycle, asserts done, then returns to IDLE.
- Load handshake:
  - A transfer happens when load_valid && load_ready on a clk edge. The word is written at mem[wr_ptr], then wr_ptr and prog_len increment.
  - load_ready = (state==IDLE) && (prog_len<DEPTH) && !clear.
  - At prog_len==DEPTH, load_ready=0 and further load_valid is ignored; there is no overwrite.
- clear:
  - Honoured only in IDLE; wr_ptr and prog_len go to 0 on the next edge.
  - clear has priority over a simultaneous load (no write) and over start (start is ignored).
- All instruction outputs are registered.
  - If start is sampled at edge t, mem[0] appears on inst_hi/lo with inst_valid=1 after edge t+1 and is held for one cycle, so the core executes it at edge t+2.
- RUN, per edge, in priority order:
  - stop: go to IDLE, output NOP, inst_valid=0, pc=0, no done pulse.
  - hold: pc unchanged, output NOP, inst_valid=0.
  - Otherwise issue mem[pc]. If pc==prog_len-1:
    - loop_en=1: pc := 0.
    - loop_en=0: next state is DONE.
  - Otherwise pc := pc+1.
- Every word is issued exactly once per pass, including when prog_len==1. With looping and no hold, words repeat back-to-back with no bubble.
- loop_en is sampled at the moment the last word is issued, so it may change mid-run.
- busy = (state==RUN).
- DONE state:
  - Outputs NOP with inst_valid=0, pulses done=1 for one cycle, then goes to IDLE.
  - The program is retained, so a new start replays it.
- start while in RUN or DONE is ignored. Loads during RUN or DONE are refused because load_ready=0.
- Asynchronous rst at any point, including mid-replay, forces the reset values immediately. NOP is then on the outputs, so the core sees no spurious write.

Decomposition:
- Shared package/header:
  - opcode constants (MVR, LDB, STB, RDS, NOP=4'b0100, and the arithmetic ops) and NOP_WORD, moved out of tt_um_8bit_cpu so the core and the sequencer share one definition.
  - state encoding constants SEQ_IDLE, SEQ_RUN, SEQ_DONE.
- One sub-module: prog_mem.
  - DEPTH x 16, one synchronous write port and one asynchronous read port.
  - No reset on the array.
- Sequencer FSM, pointers and output register live in inst_sequencer.
- Top-level integration muxes inst_hi/inst_lo into the core's ui_in/uio_in.

Test Plan:
1. Reset, then load 3 words: 0x1_0_5A (LDB R0,0x5A), 0x1_1_03 (LDB R1,0x03), 0xB2_01 (ADD R2=R0+R1).
   - Required: prog_len=3.
   - Pulse start: inst_valid high for exactly 3 consecutive cycles carrying those words in order, then a done pulse one cycle after the last word, then NOP and busy=0.
2. Load DEPTH=16 words while load_valid is held high.
   - Required: load_ready falls after the 16th transfer; a 17th word is not written; prog_len=16.
3. Load 2 words with loop_en=1 and start, run 7 cycles, assert stop.
   - Required: words issued w0,w1,w0,w1,w0,w1,w0; NOP on the cycle after stop; no done pulse.
4. Load 4 words, start, assert hold for 2 cycles after w1.
   - Required: output sequence w0,w1,NOP,NOP,w2,w3; inst_valid=0 during hold; done after w3.
5. In IDLE with prog_len=3, assert clear together with load_valid and start.
   - Required: prog_len=0, no write, state stays IDLE; a later start is ignored (busy stays 0).
6. Assert rst mid-replay at pc=2.
   - Required: outputs show NOP_WORD and inst_valid=0 asynchronously, prog_len=0, load_ready=1 on release.
   - With the core attached, its registers show no write from the aborted cycle.

Source files
------------

// File: rtl/inst_sequencer_pkg.sv
// Shared instruction-set constants for tt_um_8bit_cpu and its instruction sequencer.
package inst_sequencer_pkg;

  localparam logic [3:0] OP_MVR = 4'h0;
  localparam logic [3:0] OP_LDB = 4'h1;
  localparam logic [3:0] OP_STB = 4'h2;
  localparam logic [3:0] OP_RDS = 4'h3;
  localparam logic [3:0] OP_NOP = 4'h4;
  localparam logic [3:0] OP_ADD = 4'hB;
  localparam logic [3:0] OP_SUB = 4'hC;
  localparam logic [3:0] OP_AND = 4'hD;
  localparam logic [3:0] OP_OR  = 4'hE;
  localparam logic [3:0] OP_XOR = 4'hF;

  localparam logic [15:0] NOP_WORD = {OP_NOP, 12'h000};

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/inst_sequencer_prog_mem.sv
// Program buffer: DEPTH x 16, synchronous write, asynchronous read, array not reset.
module prog_mem #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [15:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [15:0]       rdata_o
);

  logic [15:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_sequencer.sv
// Loads a program buffer over valid/ready and replays it one word per clock,
// driving the NOP encoding whenever no program word is being issued.
module inst_sequencer #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter logic [15:0] NOP_WORD = inst_sequencer_pkg::NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_valid,
  input  logic [15:0]     load_word,
  output logic            load_ready,
  input  logic            clear,
  input  logic            start,
  input  logic            stop,
  input  logic            hold,
  input  logic            loop_en,
  output logic [7:0]      inst_hi,
  output logic [7:0]      inst_lo,
  output logic            inst_valid,
  output logic            busy,
  output logic            done,
  output logic [ADDR_W:0] prog_len
);

  import inst_sequencer_pkg::*;

  localparam logic [ADDR_W:0] LEN_FULL = (ADDR_W+1)'(DEPTH);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [15:0]       word_q, word_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [15:0]       rd_word;
  logic              ld_fire;
  logic              last;

  assign load_ready = (state_q == SEQ_IDLE) && (len_q < LEN_FULL) && !clear;
  assign ld_fire    = load_valid && load_ready;
  assign last       = ({1'b0, pc_q} == (len_q - 1'b1));

  prog_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_prog_mem (
    .clk     (clk),
    .we_i    (ld_fire),
    .waddr_i (wr_ptr_q),
    .wdata_i (load_word),
    .raddr_i (pc_q),
    .rdata_o (rd_word)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    len_d    = len_q;
    word_d   = NOP_WORD;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        // clear wins over a simultaneous load or start
        if (clear) begin
          wr_ptr_d = '0;
          len_d    = '0;
        end else begin
          if (ld_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            len_d    = len_q + 1'b1;
          end
          if (start && (len_q != '0)) begin
            state_d = SEQ_RUN;
            pc_d    = '0;
          end
        end
      end
      SEQ_RUN: begin
        if (stop) begin
          state_d = SEQ_IDLE;
          pc_d    = '0;
        end else if (!hold) begin
          word_d  = rd_word;
          valid_d = 1'b1;
          if (last) begin
            pc_d = '0;
            if (!loop_en) state_d = SEQ_DONE;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      SEQ_DONE: begin
        done_d  = 1'b1;
        state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SEQ_IDLE;
      pc_q     <= '0;
      wr_ptr_q <= '0;
      len_q    <= '0;
      word_q   <= NOP_WORD;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      len_q    <= len_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign inst_hi    = word_q[15:8];
  assign inst_lo    = word_q[7:0];
  assign inst_valid = valid_q;
  assign busy       = (state_q == SEQ_RUN);
  assign done       = done_q;
  assign prog_len   = len_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed plus randomized checks of inst_sequencer against a queue-based program model.
module tb_inst_sequencer;

  localparam logic [15:0] NOP = 16'h4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid, clear, start, stop, hold, loop_en;
  logic [15:0] load_word;
  logic        load_ready, inst_valid, busy, done;
  logic [7:0]  inst_hi, inst_lo;
  logic [4:0]  prog_len;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [15:0] prog_q[$];

  inst_sequencer #(
    .DEPTH    (16),
    .ADDR_W   (4),
    .NOP_WORD (16'h4000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_word  (load_word),
    .load_ready (load_ready),
    .clear      (clear),
    .start      (start),
    .stop       (stop),
    .hold       (hold),
    .loop_en    (loop_en),
    .inst_hi    (inst_hi),
    .inst_lo    (inst_lo),
    .inst_valid (inst_valid),
    .busy       (busy),
    .done       (done),
    .prog_len   (prog_len)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] w, input logic v);
    chk({tag, ".word"}, {16'h0, inst_hi, inst_lo}, {16'h0, w});
    chk({tag, ".valid"}, {31'h0, inst_valid}, {31'h0, v});
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    prog_q.delete();
    chk("clear.len", {27'h0, prog_len}, 32'd0);
  endtask

  task automatic load_one(input logic [15:0] w);
    load_valid = 1'b1;
    load_word  = w;
    #1;
    chk("load.ready", {31'h0, load_ready}, 32'd1);
    step();
    load_valid = 1'b0;
    prog_q.push_back(w);
  endtask

  // Replays the model program with a random hold pattern; loop_en is low.
  task automatic replay(input string tag, input int unsigned hold_pct);
    int unsigned idx;
    int unsigned cyc;
    logic        h;
    idx = 0;
    cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, ".busy0"}, {31'h0, busy}, 32'd1);
    chk_out({tag, ".pre"}, NOP, 1'b0);
    while (idx < prog_q.size() && cyc < 300) begin
      h = ($urandom_range(0, 99) < hold_pct);
      hold = h;
      step();
      if (h) begin
        chk_out({tag, ".hold"}, NOP, 1'b0);
      end else begin
        chk_out({tag, ".issue"}, prog_q[idx], 1'b1);
        idx++;
      end
      chk({tag, ".busy"}, {31'h0, busy}, {31'h0, (idx < prog_q.size())});
      cyc++;
    end
    hold = 1'b0;
    chk({tag, ".bound"}, idx, prog_q.size());
    step();
    chk({tag, ".done"}, {31'h0, done}, 32'd1);
    chk_out({tag, ".done_nop"}, NOP, 1'b0);
    step();
    chk({tag, ".done_end"}, {31'h0, done}, 32'd0);
    chk({tag, ".idle"}, {31'h0, busy}, 32'd0);
  endtask

  initial begin
    int unsigned n;
    int unsigned acc;
    logic        exp_ready;
    rst = 1'b1;
    load_valid = 1'b0; load_word = '0; clear = 1'b0; start = 1'b0;
    stop = 1'b0; hold = 1'b0; loop_en = 1'b0;

    // reset values
    #3;
    chk_out("rst", NOP, 1'b0);
    chk("rst.busy", {31'h0, busy}, 32'd0);
    chk("rst.done", {31'h0, done}, 32'd0);
    chk("rst.len", {27'h0, prog_len}, 32'd0);
    chk("rst.ready", {31'h0, load_ready}, 32'd1);
    #4 rst = 1'b0;
    step();

    // 1: three-word program
    load_one(16'h105A);
    load_one(16'h1103);
    load_one(16'hB201);
    chk("t1.len", {27'h0, prog_len}, 32'd3);
    replay("t1", 0);
    replay("t1.again", 0);

    // 2: fill to DEPTH with load_valid held; the 17th word must be refused
    do_clear();
    acc = 0;
    load_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      load_word = 16'($urandom);
      #1;
      exp_ready = (acc < 16);
      chk("t2.ready", {31'h0, load_ready}, {31'h0, exp_ready});
      if (exp_ready) begin
        prog_q.push_back(load_word);
        acc++;
      end
      step();
    end
    load_valid = 1'b0;
    chk("t2.len", {27'h0, prog_len}, 32'd16);
    chk("t2.ready_full", {31'h0, load_ready}, 32'd0);
    replay("t2", 0);

    // 3: two-word loop, stop after 7 issues
    do_clear();
    load_one(16'h0123);
    load_one(16'h2345);
    loop_en = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk_out("t3.loop", prog_q[i % 2], 1'b1);
      chk("t3.busy", {31'h0, busy}, 32'd1);
      chk("t3.nodone", {31'h0, done}, 32'd0);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_out("t3.stop", NOP, 1'b0);
    chk("t3.busy_stop", {31'h0, busy}, 32'd0);
    step();
    chk("t3.nodone_after", {31'h0, done}, 32'd0);
    chk_out("t3.after", NOP, 1'b0);

    // 3b: single-word loop repeats with no bubble
    do_clear();
    load_one(16'h1777);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out("t3b.loop1", 16'h1777, 1'b1);
    end
    loop_en = 1'b0;
    step();
    chk_out("t3b.last", 16'h1777, 1'b1);
    step();
    chk("t3b.done", {31'h0, done}, 32'd1);
    chk_out("t3b.done_nop", NOP, 1'b0);
    step();

    // 4: hold for two cycles after w1
    do_clear();
    for (int i = 0; i < 4; i++) load_one(16'hA000 + 16'(i));
    start = 1'b1;
    step();
    start = 1'b0;
    step(); chk_out("t4.w0", prog_q[0], 1'b1);
    step(); chk_out("t4.w1", prog_q[1], 1'b1);
    hold = 1'b1;
    step(); chk_out("t4.h0", NOP, 1'b0);
    step(); chk_out("t4.h1", NOP, 1'b0);
    chk("t4.busy_hold", {31'h0, busy}, 32'd1);
    hold = 1'b0;
    step(); chk_out("t4.w2", prog_q[2], 1'b1);
    step(); chk_out("t4.w3", prog_q[3], 1'b1);
    step(); chk("t4.done", {31'h0, done}, 32'd1);
    step(); chk("t4.done_end", {31'h0, done}, 32'd0);

    // 5: clear beats a simultaneous load and start
    do_clear();
    for (int i = 0; i < 3; i++) load_one(16'h3300 + 16'(i));
    chk("t5.len3", {27'h0, prog_len}, 32'd3);
    clear = 1'b1; load_valid = 1'b1; load_word = 16'hDEAD; start = 1'b1;
    #1;
    chk("t5.ready", {31'h0, load_ready}, 32'd0);
    step();
    clear = 1'b0; load_valid = 1'b0;
    prog_q.delete();
    chk("t5.len0", {27'h0, prog_len}, 32'd0);
    chk("t5.busy", {31'h0, busy}, 32'd0);
    step();
    start = 1'b0;
    chk("t5.start_ignored", {31'h0, busy}, 32'd0);
    chk_out("t5.nop", NOP, 1'b0);
    load_one(16'h1234);
    replay("t5.new", 0);

    // 6: asynchronous reset mid-replay at pc=2
    do_clear();
    for (int i = 0; i < 4; i++) load_one(16'h5500 + 16'(i));
    start = 1'b1;
    step();
    start = 1'b0;
    step(); chk_out("t6.w0", prog_q[0], 1'b1);
    step(); chk_out("t6.w1", prog_q[1], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_out("t6.async", NOP, 1'b0);
    chk("t6.len", {27'h0, prog_len}, 32'd0);
    chk("t6.busy", {31'h0, busy}, 32'd0);
    #1 rst = 1'b0;
    #1;
    chk("t6.ready", {31'h0, load_ready}, 32'd1);
    step();
    chk_out("t6.stays_nop", NOP, 1'b0);
    chk("t6.done", {31'h0, done}, 32'd0);
    prog_q.delete();

    // randomized programs with random hold
    for (int r = 0; r < 6; r++) begin
      do_clear();
      n = (r == 0) ? 1 : $urandom_range(1, 16);
      for (int i = 0; i < int'(n); i++) load_one(16'($urandom));
      chk("rand.len", {27'h0, prog_len}, n);
      replay("rand", 30);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
